// File: rtl/fll_ctrl_defs_pkg.sv
// -----------------------------------------------------------------------------
// fll_ctrl_defs
// Shared definitions for the I2S FLL frequency-adjust controller.
//   - fll_state_t : controller state encoding (also exported on state_o)
//   - DIR_*       : direction of the pending adjust request
//   - NET_MAX/MIN : saturation limits of the signed net-adjust counter
//   - net_step()  : one saturating +1/-1 step of the net-adjust counter
// -----------------------------------------------------------------------------
package fll_ctrl_defs;

   typedef enum logic [1:0] {
      FLL_IDLE    = 2'd0,
      FLL_QUALIFY = 2'd1,
      FLL_ASSERT  = 2'd2,
      FLL_HOLDOFF = 2'd3
   } fll_state_t;

   localparam logic DIR_SPEEDUP  = 1'b0;
   localparam logic DIR_SLOWDOWN = 1'b1;

   localparam logic signed [15:0] NET_MAX = 16'sh7FFF;
   localparam logic signed [15:0] NET_MIN = 16'sh8000;

   // Speedups count up, slowdowns count down; the count sticks at its
   // limits so firmware reading it never sees a wrap-around sign flip.
   function automatic logic signed [15:0] net_step(input logic signed [15:0] net,
                                                   input logic dir);
      logic signed [15:0] result;
      result = net;
      if (dir == DIR_SPEEDUP) begin
         if (net != NET_MAX) result = net + 16'sd1;
      end else begin
         if (net != NET_MIN) result = net - 16'sd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fll_sync2.sv
// -----------------------------------------------------------------------------
// fll_sync2
// Two-flop synchronizer bringing an asynchronous level into the WB_CLK domain.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both flops
//   d   : asynchronous input level
//   q   : synchronized level, two clk edges after d settles
// -----------------------------------------------------------------------------
module fll_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // First flop may go metastable; the second gives it a full cycle to settle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/fll_adjust_ctrl.sv
// -----------------------------------------------------------------------------
// fll_adjust_ctrl
// Qualifies the FLL word-count comparison flags, raises one speedup/slowdown
// interrupt toward the M4, waits for firmware acknowledge, then holds off so
// the clock-adjust loop cannot chatter.
//   WB_CLK, WB_RST         : Wishbone clock, async active-high reset
//   enable_i               : controller enable; low forces IDLE, drops interrupts
//   master_ahead_i         : async flag, master word count ahead (speed up)
//   local_ahead_i          : async flag, local word count ahead (slow down)
//   persist_i              : extra cycles the condition must persist
//   holdoff_i              : holdoff cycles after acknowledge
//   int_ack_i              : firmware acknowledge pulse, honoured in ASSERT only
//   Interrupt_speedup_o    : level, local clock must speed up
//   Interrupt_slowdown_o   : level, local clock must slow down
//   state_o                : current controller state (debug)
//   net_adjust_o           : saturating speedups-minus-slowdowns count
//   FB_msg_out             : {Interrupt_speedup_o, Interrupt_slowdown_o}
// -----------------------------------------------------------------------------
module fll_adjust_ctrl
   import fll_ctrl_defs::*;
#(
   parameter int PERSIST_W = 8,
   parameter int HOLDOFF_W = 16
) (
   input  logic                  WB_CLK,
   input  logic                  WB_RST,
   input  logic                  enable_i,
   input  logic                  master_ahead_i,
   input  logic                  local_ahead_i,
   input  logic [PERSIST_W-1:0]  persist_i,
   input  logic [HOLDOFF_W-1:0]  holdoff_i,
   input  logic                  int_ack_i,
   output logic                  Interrupt_speedup_o,
   output logic                  Interrupt_slowdown_o,
   output logic [1:0]            state_o,
   output logic signed [15:0]    net_adjust_o,
   output logic [1:0]            FB_msg_out
);

   logic                 m_s;
   logic                 l_s;
   logic                 spd_cond;
   logic                 slw_cond;
   logic                 dir_cond;

   fll_state_t           state_q;
   fll_state_t           state_d;
   logic                 dir_q;
   logic                 dir_d;
   logic [PERSIST_W-1:0] qual_q;
   logic [PERSIST_W-1:0] qual_d;
   logic [HOLDOFF_W-1:0] hold_q;
   logic [HOLDOFF_W-1:0] hold_d;
   logic                 bump;
   logic signed [15:0]   net_q;
   logic                 spd_int_q;
   logic                 slw_int_q;

   fll_sync2 u_sync_master (
      .clk (WB_CLK),
      .rst (WB_RST),
      .d   (master_ahead_i),
      .q   (m_s)
   );

   fll_sync2 u_sync_local (
      .clk (WB_CLK),
      .rst (WB_RST),
      .d   (local_ahead_i),
      .q   (l_s)
   );

   // Both flags high (or both low) means the comparison is ambiguous and no
   // adjust is requested; dir_cond tracks only the direction being qualified.
   assign spd_cond = m_s & ~l_s;
   assign slw_cond = l_s & ~m_s;
   assign dir_cond = (dir_q == DIR_SPEEDUP) ? spd_cond : slw_cond;

   // Next-state logic. The persistence compare happens before the increment,
   // so qual_q never has to count past persist_i and cannot wrap; likewise
   // hold_q is tested for zero before it is decremented. bump marks the single
   // cycle on which ASSERT is entered so net_adjust moves once per request.
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      qual_d  = qual_q;
      hold_d  = hold_q;
      bump    = 1'b0;
      if (!enable_i) begin
         state_d = FLL_IDLE;
      end else begin
         unique case (state_q)
            FLL_IDLE: begin
               if (spd_cond || slw_cond) begin
                  dir_d   = slw_cond ? DIR_SLOWDOWN : DIR_SPEEDUP;
                  qual_d  = '0;
                  state_d = FLL_QUALIFY;
               end
            end
            FLL_QUALIFY: begin
               if (dir_cond && (qual_q == persist_i)) begin
                  state_d = FLL_ASSERT;
                  bump    = 1'b1;
               end else if (dir_cond) begin
                  qual_d = qual_q + PERSIST_W'(1);
               end else begin
                  state_d = FLL_IDLE;
               end
            end
            FLL_ASSERT: begin
               if (int_ack_i) begin
                  hold_d  = holdoff_i;
                  state_d = FLL_HOLDOFF;
               end
            end
            FLL_HOLDOFF: begin
               if (hold_q == '0) begin
                  state_d = FLL_IDLE;
               end else begin
                  hold_d = hold_q - HOLDOFF_W'(1);
               end
            end
            default: state_d = FLL_IDLE;
         endcase
      end
   end

   // State and counter registers. The interrupt levels are registered from
   // the next state so they are high exactly while the FSM sits in ASSERT,
   // and can never both be high because dir selects only one of them.
   always_ff @(posedge WB_CLK or posedge WB_RST) begin
      if (WB_RST) begin
         state_q   <= FLL_IDLE;
         dir_q     <= DIR_SPEEDUP;
         qual_q    <= '0;
         hold_q    <= '0;
         net_q     <= '0;
         spd_int_q <= 1'b0;
         slw_int_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         qual_q    <= qual_d;
         hold_q    <= hold_d;
         spd_int_q <= (state_d == FLL_ASSERT) && (dir_d == DIR_SPEEDUP);
         slw_int_q <= (state_d == FLL_ASSERT) && (dir_d == DIR_SLOWDOWN);
         if (bump) begin
            net_q <= net_step(net_q, dir_d);
         end
      end
   end

   assign Interrupt_speedup_o  = spd_int_q;
   assign Interrupt_slowdown_o = slw_int_q;
   assign state_o              = state_q;
   assign net_adjust_o         = net_q;
   assign FB_msg_out           = {spd_int_q, slw_int_q};

endmodule

// File: tb/tb_fll_adjust_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fll_adjust_ctrl
// Scoreboard bench for fll_adjust_ctrl. Stimulus pushes the expected cycle,
// direction and net count of every interrupt rise; a monitor pops and compares
// whenever an interrupt rises. Directed checks cover reset, state and
// disable/reset behaviour.
// -----------------------------------------------------------------------------
module tb_fll_adjust_ctrl;
   import fll_ctrl_defs::*;

   typedef struct {
      int               cyc;
      logic             dir;
      logic signed [15:0] net;
   } exp_t;

   logic               WB_CLK;
   logic               WB_RST;
   logic               enable_i;
   logic               master_ahead_i;
   logic               local_ahead_i;
   logic [7:0]         persist_i;
   logic [15:0]        holdoff_i;
   logic               int_ack_i;
   logic               Interrupt_speedup_o;
   logic               Interrupt_slowdown_o;
   logic [1:0]         state_o;
   logic signed [15:0] net_adjust_o;
   logic [1:0]         FB_msg_out;

   int   cyc = 0;
   int   pass_count = 0;
   int   check_count = 0;
   exp_t exp_q[$];
   logic prev_spd = 1'b0;
   logic prev_slw = 1'b0;

   fll_adjust_ctrl #(.PERSIST_W(8), .HOLDOFF_W(16)) dut (
      .WB_CLK               (WB_CLK),
      .WB_RST               (WB_RST),
      .enable_i             (enable_i),
      .master_ahead_i       (master_ahead_i),
      .local_ahead_i        (local_ahead_i),
      .persist_i            (persist_i),
      .holdoff_i            (holdoff_i),
      .int_ack_i            (int_ack_i),
      .Interrupt_speedup_o  (Interrupt_speedup_o),
      .Interrupt_slowdown_o (Interrupt_slowdown_o),
      .state_o              (state_o),
      .net_adjust_o         (net_adjust_o),
      .FB_msg_out           (FB_msg_out)
   );

   // 10-unit clock; cyc counts rising edges so expected rise times can be
   // expressed as "edges after the stimulus was applied".
   initial WB_CLK = 1'b0;
   always #5 WB_CLK = ~WB_CLK;
   always @(posedge WB_CLK) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      check_count++;
      if (actual == expected) pass_count++;
      else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
   endtask

   task automatic applyStimulus(input logic en, input logic m, input logic l, input logic ack);
      @(negedge WB_CLK);
      enable_i       = en;
      master_ahead_i = m;
      local_ahead_i  = l;
      int_ack_i      = ack;
   endtask

   task automatic pushExpect(input int at_cyc, input logic dir, input int net);
      exp_t e;
      e.cyc = at_cyc;
      e.dir = dir;
      e.net = 16'(net);
      exp_q.push_back(e);
   endtask

   task automatic waitRise(input string name, input int limit);
      int n;
      n = 0;
      while (!(Interrupt_speedup_o || Interrupt_slowdown_o) && n < limit) begin
         @(negedge WB_CLK);
         n++;
      end
      if (!(Interrupt_speedup_o || Interrupt_slowdown_o))
         checkOutput({"timeout_", name}, 0, 1);
   endtask

   task automatic waitUntil(input int target);
      while (cyc < target) @(negedge WB_CLK);
   endtask

   // Acknowledge sampled on the next rising edge, released one cycle later.
   task automatic ackPulse();
      int_ack_i = 1'b1;
      @(negedge WB_CLK);
      int_ack_i = 1'b0;
   endtask

   // Monitor: every interrupt rise must match the oldest expected entry.
   always @(negedge WB_CLK) begin
      exp_t e;
      if (WB_RST) begin
         prev_spd <= 1'b0;
         prev_slw <= 1'b0;
      end else begin
         if ((Interrupt_speedup_o && !prev_spd) || (Interrupt_slowdown_o && !prev_slw)) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_rise", 1, 0);
            end else begin
               e = exp_q.pop_front();
               checkOutput("rise_cycle", cyc, e.cyc);
               checkOutput("rise_dir_spd", int'(Interrupt_speedup_o), int'(e.dir == DIR_SPEEDUP));
               checkOutput("rise_dir_slw", int'(Interrupt_slowdown_o), int'(e.dir == DIR_SLOWDOWN));
               checkOutput("rise_net", int'(net_adjust_o), int'(e.net));
            end
         end
         prev_spd <= Interrupt_speedup_o;
         prev_slw <= Interrupt_slowdown_o;
      end
   end

   // Global watchdog so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n0;
      int ack_edge;
      WB_RST = 1'b1;
      enable_i = 1'b0;
      master_ahead_i = 1'b0;
      local_ahead_i = 1'b0;
      int_ack_i = 1'b0;
      persist_i = 8'd3;
      holdoff_i = 16'd0;

      // Reset values
      @(negedge WB_CLK);
      checkOutput("reset_spd", int'(Interrupt_speedup_o), 0);
      checkOutput("reset_slw", int'(Interrupt_slowdown_o), 0);
      checkOutput("reset_state", int'(state_o), 0);
      checkOutput("reset_net", int'(net_adjust_o), 0);
      checkOutput("reset_fb", int'(FB_msg_out), 0);
      @(negedge WB_CLK);
      WB_RST = 1'b0;

      // Speedup with persist 3: rise 7 edges after master goes high
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      n0 = cyc;
      pushExpect(n0 + 7, DIR_SPEEDUP, 1);
      waitRise("speedup", 20);
      checkOutput("fb_msg_speedup", int'(FB_msg_out), 2);
      ackPulse();
      master_ahead_i = 1'b0;
      checkOutput("ack_spd_low", int'(Interrupt_speedup_o), 0);
      checkOutput("ack_state_holdoff", int'(state_o), 3);
      waitUntil(cyc + 10);
      checkOutput("after_speedup_idle", int'(state_o), 0);

      // Glitch rejection: local high for 4 edges with persist 5
      persist_i = 8'd5;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      repeat (4) @(negedge WB_CLK);
      local_ahead_i = 1'b0;
      waitUntil(cyc + 12);
      checkOutput("glitch_state", int'(state_o), 0);
      checkOutput("glitch_net", int'(net_adjust_o), 1);

      // Reversal: start fresh so the slowdown lands at -1
      WB_RST = 1'b1;
      @(negedge WB_CLK);
      WB_RST = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      n0 = cyc;
      waitUntil(n0 + 4);
      checkOutput("reversal_qualify", int'(state_o), 1);
      local_ahead_i = 1'b1;
      waitUntil(n0 + 9);
      checkOutput("reversal_idle", int'(state_o), 0);
      master_ahead_i = 1'b0;
      n0 = cyc;
      pushExpect(n0 + 9, DIR_SLOWDOWN, -1);
      waitRise("slowdown", 25);
      checkOutput("fb_msg_slowdown", int'(FB_msg_out), 1);
      ackPulse();
      local_ahead_i = 1'b0;
      waitUntil(cyc + 20);
      checkOutput("after_slowdown_idle", int'(state_o), 0);

      // Holdoff 10, persist 2, master held through the acknowledge
      persist_i = 8'd2;
      holdoff_i = 16'd10;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      n0 = cyc;
      pushExpect(n0 + 6, DIR_SPEEDUP, 0);
      waitRise("holdoff_first", 20);
      ack_edge = cyc + 1;
      pushExpect(ack_edge + 11 + 1 + 2 + 1, DIR_SPEEDUP, 1);
      ackPulse();
      waitRise("holdoff_second", 40);

      // Disable while in ASSERT
      enable_i = 1'b0;
      @(negedge WB_CLK);
      checkOutput("disable_spd_low", int'(Interrupt_speedup_o), 0);
      checkOutput("disable_state", int'(state_o), 0);
      checkOutput("disable_net_kept", int'(net_adjust_o), 1);
      master_ahead_i = 1'b0;
      repeat (5) @(negedge WB_CLK);

      // Reset while in HOLDOFF
      persist_i = 8'd0;
      holdoff_i = 16'd10;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      n0 = cyc;
      pushExpect(n0 + 4, DIR_SPEEDUP, 2);
      waitRise("pre_reset", 15);
      ackPulse();
      checkOutput("pre_reset_holdoff", int'(state_o), 3);
      master_ahead_i = 1'b0;
      #2;
      WB_RST = 1'b1;
      #1;
      checkOutput("async_reset_spd", int'(Interrupt_speedup_o), 0);
      checkOutput("async_reset_slw", int'(Interrupt_slowdown_o), 0);
      checkOutput("async_reset_state", int'(state_o), 0);
      checkOutput("async_reset_net", int'(net_adjust_o), 0);
      @(negedge WB_CLK);
      WB_RST = 1'b0;

      // Saturation: preload the count near the top, then ack every request
      persist_i = 8'd0;
      holdoff_i = 16'd0;
      @(negedge WB_CLK);
      force dut.net_q = 16'sh7FFD;
      #1;
      release dut.net_q;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      n0 = cyc;
      pushExpect(n0 + 4, DIR_SPEEDUP, 32766);
      pushExpect(n0 + 8, DIR_SPEEDUP, 32767);
      pushExpect(n0 + 12, DIR_SPEEDUP, 32767);
      pushExpect(n0 + 16, DIR_SPEEDUP, 32767);
      waitUntil(n0 + 14);
      master_ahead_i = 1'b0;
      waitUntil(n0 + 22);
      int_ack_i = 1'b0;
      checkOutput("saturated_net", int'(net_adjust_o), 32767);
      checkOutput("saturated_idle", int'(state_o), 0);

      repeat (3) @(negedge WB_CLK);
      checkOutput("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
